// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants and types for the VGA framebuffer scanout
//               path: active-region origin, framebuffer geometry, cell codes,
//               RGB triple and the scanout state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACT_START = 144;
    localparam int V_ACT_START = 35;
    localparam int FB_W        = 160;
    localparam int FB_H        = 120;

    // Stored per-cell code. Bit 1 / bit 0 map directly to {outside, inside}.
    typedef enum logic [1:0] {
        CELL_BG    = 2'd0,
        CELL_IN    = 2'd1,
        CELL_OUT   = 2'd2,
        CELL_WHITE = 2'd3
    } cell_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } scan_state_t;

    function automatic rgb_t cell_to_rgb(input cell_t code);
        rgb_t c;
        case (code)
            CELL_IN:    c = {4'hF, 4'h0, 4'h0};
            CELL_OUT:   c = {4'h0, 4'h0, 4'hF};
            CELL_WHITE: c = {4'hF, 4'hF, 4'hF};
            default:    c = {4'h0, 4'h0, 4'h0};
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_ram.sv
`default_nettype none
// ============================================================================
// Module      : fb_ram
// Description : Single-port framebuffer RAM, DEPTH x 2 bits, synchronous read
//               (read-before-write). Contents are not reset.
// Ports       : clk_i   - clock
//               we_i    - write enable
//               addr_i  - shared read/write address
//               wdata_i - write data (cell code)
//               rdata_o - registered read data of addr_i from previous cycle
// Revision    : 1.0 - initial release
// ============================================================================
module fb_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [1:0]    wdata_i,
    output logic [1:0]    rdata_o
);

    localparam int c_iw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0] mem_q [DEPTH];
    logic [1:0] rdata_q;
    logic       in_range;

    // Addresses past the last cell (e.g. blanking-region reads) are ignored
    // on write and read back as background.
    assign in_range = ({{(32-AW){1'b0}}, addr_i} < 32'(DEPTH));

    always_ff @(posedge clk_i) begin
        if (we_i && in_range) begin
            mem_q[addr_i[c_iw-1:0]] <= wdata_i;
        end
        rdata_q <= in_range ? mem_q[addr_i[c_iw-1:0]] : 2'b00;
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vga_frame_scanout.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_scanout
// Description : Pixel-data stage after the VGA sync generator. Holds a
//               FB_W x FB_H framebuffer of 2-bit cells (each drawn as a 4x4
//               screen block), accepts point writes over valid/ready, wipes
//               the buffer after reset or on clear_req, and emits 4-bit RGB
//               with HS/VS delayed to stay pixel-aligned.
// Config      : SCANOUT_BORDER_EN - when defined, the outermost ring of cells
//               is drawn white regardless of stored code. Latency unchanged.
// Ports       : clk100, reset           - clock, sync active-high reset
//               pix_en                  - 1-in-4 pixel strobe
//               h_count, v_count        - raster position
//               hs_in, vs_in, vid_sel   - raw syncs / visible flag
//               pt_valid/pt_ready, pt_x, pt_y, pt_inside - point write port
//               clear_req, clear_busy   - wipe request / wipe in progress
//               pt_count                - saturating count of stored points
//               vga_r/g/b, vga_hs/vs    - aligned video outputs
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_scanout #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int H_ACT_START = 144,
    parameter int V_ACT_START = 35
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        vid_sel,
    input  logic        pt_valid,
    output logic        pt_ready,
    input  logic [7:0]  pt_x,
    input  logic [6:0]  pt_y,
    input  logic        pt_inside,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic [15:0] pt_count,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs
);

    import vga_pkg::*;

    localparam int          c_depth     = FB_W * FB_H;
    localparam logic [14:0] c_last_addr = 15'(c_depth - 1);
    localparam logic [14:0] c_fb_w      = 15'(FB_W);
    localparam logic [14:0] c_fb_h      = 15'(FB_H);

    // ------------------------------------------------------------------
    // Read address from raster counts (15-bit arithmetic throughout)
    // ------------------------------------------------------------------
    logic [14:0] rd_x, rd_y, rd_addr;

    assign rd_x    = (15'(h_count) - 15'(H_ACT_START)) >> 2;
    assign rd_y    = (15'(v_count) - 15'(V_ACT_START)) >> 2;
    assign rd_addr = rd_y * c_fb_w + rd_x;

    // ------------------------------------------------------------------
    // Point write address / range check
    // ------------------------------------------------------------------
    logic [14:0] pt_x15, pt_y15, wr_addr;
    logic        pt_in_range;

    assign pt_x15      = {7'd0, pt_x};
    assign pt_y15      = {8'd0, pt_y};
    assign pt_in_range = (pt_x15 < c_fb_w) && (pt_y15 < c_fb_h);
    assign wr_addr     = pt_y15 * c_fb_w + pt_x15;

    // ------------------------------------------------------------------
    // Control FSM: owns the RAM port on non-pix_en cycles
    // ------------------------------------------------------------------
    scan_state_t state_q, state_d;
    logic [14:0] clr_addr_q, clr_addr_d;
    logic [15:0] pt_count_q, pt_count_d;
    logic        ready_w;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [1:0]  ram_wdata;
    logic [1:0]  ram_rdata;

    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= 15'd0;
            pt_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            pt_count_q <= pt_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        pt_count_d = pt_count_q;
        ready_w    = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = rd_addr;
        ram_wdata  = CELL_BG;
        case (state_q)
            ST_IDLE: begin
                // Reads own pix_en cycles; a same-cycle clear_req beats the point.
                ready_w = ~pix_en & ~clear_req;
                if (clear_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = 15'd0;
                    pt_count_d = 16'd0;
                end else if (pt_valid && ready_w && pt_in_range) begin
                    ram_we    = 1'b1;
                    ram_addr  = wr_addr;
                    ram_wdata = {~pt_inside, pt_inside};
                    if (pt_count_q != 16'hFFFF) begin
                        pt_count_d = pt_count_q + 16'd1;
                    end
                end
            end
            ST_CLEAR: begin
                // clear_req is ignored here: the running wipe is not restarted.
                if (!pix_en) begin
                    ram_we   = 1'b1;
                    ram_addr = clr_addr_q;
                    if (clr_addr_q == c_last_addr) begin
                        state_d = ST_IDLE;
                    end else begin
                        clr_addr_d = clr_addr_q + 15'd1;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    fb_ram #(
        .DEPTH (c_depth),
        .AW    (15)
    ) u_fb_ram (
        .clk_i   (clk100),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Output pipeline: sample at pix_en (N), RAM data at N+1, outputs N+2
    // ------------------------------------------------------------------
    logic pix_d1_q;
    logic s1_hs_q, s1_vs_q, s1_vis_q;
    rgb_t pix_rgb;
    rgb_t rgb_q;
    logic hs_q, vs_q;

`ifdef SCANOUT_BORDER_EN
    logic s1_border_q;
    logic border_w;

    assign border_w = (rd_x == 15'd0) || (rd_x == c_fb_w - 15'd1) ||
                      (rd_y == 15'd0) || (rd_y == c_fb_h - 15'd1);

    always_ff @(posedge clk100) begin
        if (reset) begin
            s1_border_q <= 1'b0;
        end else if (pix_en) begin
            s1_border_q <= border_w;
        end
    end
`endif

    always_ff @(posedge clk100) begin
        if (reset) begin
            pix_d1_q <= 1'b0;
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_vis_q <= 1'b0;
            rgb_q    <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            pix_d1_q <= pix_en;
            if (pix_en) begin
                s1_hs_q  <= hs_in;
                s1_vs_q  <= vs_in;
                s1_vis_q <= vid_sel;
            end
            if (pix_d1_q) begin
                rgb_q <= pix_rgb;
                hs_q  <= s1_hs_q;
                vs_q  <= s1_vs_q;
            end
        end
    end

    always_comb begin
        pix_rgb = cell_to_rgb(cell_t'(ram_rdata));
`ifdef SCANOUT_BORDER_EN
        if (s1_border_q) begin
            pix_rgb = cell_to_rgb(CELL_WHITE);
        end
`endif
        if (!s1_vis_q) begin
            pix_rgb = '0;
        end
    end

    assign pt_ready   = ready_w;
    assign clear_busy = (state_q == ST_CLEAR);
    assign pt_count   = pt_count_q;
    assign vga_r      = rgb_q.r;
    assign vga_g      = rgb_q.g;
    assign vga_b      = rgb_q.b;
    assign vga_hs     = hs_q;
    assign vga_vs     = vs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_scanout
// Description : Directed self-checking bench for vga_frame_scanout. The DUT
//               is built with a 40x12 framebuffer so wipes stay short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_scanout;

    localparam int TB_FB_W = 40;
    localparam int TB_FB_H = 12;
    localparam int CLR_CYC = TB_FB_W * TB_FB_H * 4 / 3;

`ifdef SCANOUT_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic        clk100 = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic [9:0]  h_count = 10'd0;
    logic [9:0]  v_count = 10'd0;
    logic        hs_in = 1'b0;
    logic        vs_in = 1'b0;
    logic        vid_sel = 1'b0;
    logic        pt_valid = 1'b0;
    logic        pt_ready;
    logic [7:0]  pt_x = 8'd0;
    logic [6:0]  pt_y = 7'd0;
    logic        pt_inside = 1'b0;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic [15:0] pt_count;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always #5 clk100 = ~clk100;

    vga_frame_scanout #(
        .FB_W        (TB_FB_W),
        .FB_H        (TB_FB_H),
        .H_ACT_START (144),
        .V_ACT_START (35)
    ) dut (
        .clk100     (clk100),
        .reset      (reset),
        .pix_en     (pix_en),
        .h_count    (h_count),
        .v_count    (v_count),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .vid_sel    (vid_sel),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .pt_x       (pt_x),
        .pt_y       (pt_y),
        .pt_inside  (pt_inside),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .pt_count   (pt_count),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs)
    );

    // One clock; pix_en for the coming edge is set 1 ns after this edge.
    task automatic tick();
        @(posedge clk100);
        #1;
        cyc++;
        pix_en = (cyc % 4 == 0);
        #1;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (clear_busy && n < 4 * CLR_CYC) begin
            tick();
            n++;
        end
    endtask

    // Issue one pixel read and compare colour and syncs two cycles later.
    task automatic read_px(input logic [9:0] h, input logic [9:0] v, input logic vis,
                           input logic hs, input logic vs, input logic [11:0] exp_rgb,
                           input string nm);
        for (int k = 0; k < 4 && !pix_en; k++) tick();
        h_count = h; v_count = v; vid_sel = vis; hs_in = hs; vs_in = vs;
        tick();
        tick();
        n_total++;
        if ({vga_r, vga_g, vga_b} !== exp_rgb) begin
            n_bad++;
            $display("FAIL %s rgb: got %h want %h", nm, {vga_r, vga_g, vga_b}, exp_rgb);
        end
        n_total++;
        if ({vga_hs, vga_vs} !== {hs, vs}) begin
            n_bad++;
            $display("FAIL %s sync: got %b%b want %b%b", nm, vga_hs, vga_vs, hs, vs);
        end
    endtask

    task automatic send_pt(input logic [7:0] x, input logic [6:0] y, input logic ins,
                           output logic accepted);
        pt_valid = 1'b1; pt_x = x; pt_y = y; pt_inside = ins;
        accepted = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (pt_ready) begin
                tick();
                accepted = 1'b1;
                break;
            end
            tick();
        end
        pt_valid = 1'b0;
    endtask

    task automatic chk_count(input logic [15:0] exp_c, input string nm);
        n_total++;
        if (pt_count !== exp_c) begin
            n_bad++;
            $display("FAIL %s pt_count: got %h want %h", nm, pt_count, exp_c);
        end
    endtask

    task automatic chk_acc(input logic acc, input string nm);
        n_total++;
        if (acc !== 1'b1) begin
            n_bad++;
            $display("FAIL %s handshake: got %b want 1", nm, acc);
        end
    endtask

    task automatic chk_dur(input int n, input string nm);
        n_total++;
        if (n < CLR_CYC - 3 || n > CLR_CYC + 3 || clear_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s duration: got %0d busy=%b want %0d+-3 busy=0", nm, n, clear_busy, CLR_CYC);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; hs_in = 1'b1; vs_in = 1'b1; vid_sel = 1'b1;
        repeat (3) tick();
        n_total++;
        if (clear_busy !== 1'b1 || pt_ready !== 1'b0 || pt_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset ctrl: got busy=%b ready=%b cnt=%h want 1 0 0000", clear_busy, pt_ready, pt_count);
        end
        n_total++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset video: got %h want 0000", {vga_r, vga_g, vga_b, vga_hs, vga_vs});
        end
        hs_in = 1'b0; vs_in = 1'b0; vid_sel = 1'b0;
        reset = 1'b0;
        wait_clear(n);
        chk_dur(n, "reset wipe");
        chk_count(16'd0, "after reset wipe");
        read_px(10'd184, 10'd55, 1'b1, 1'b0, 1'b0, 12'h000, "post-wipe cell 10,5");
        read_px(10'd224, 10'd59, 1'b1, 1'b0, 1'b0, 12'h000, "post-wipe cell 20,6");
    endtask

    task automatic test_point_write();
        logic acc;
        send_pt(8'd10, 7'd5, 1'b1, acc);
        chk_acc(acc, "pt 10,5");
        chk_count(16'd1, "pt 10,5");
        read_px(10'd184, 10'd55, 1'b1, 1'b0, 1'b0, 12'hF00, "cell 10,5 tl");
        read_px(10'd187, 10'd58, 1'b1, 1'b0, 1'b0, 12'hF00, "cell 10,5 br");
        read_px(10'd183, 10'd55, 1'b1, 1'b0, 1'b0, 12'h000, "left nbr");
        read_px(10'd188, 10'd55, 1'b1, 1'b0, 1'b0, 12'h000, "right nbr");
        read_px(10'd184, 10'd54, 1'b1, 1'b0, 1'b0, 12'h000, "upper nbr");
        read_px(10'd184, 10'd59, 1'b1, 1'b0, 1'b0, 12'h000, "lower nbr");
        read_px(10'd184, 10'd55, 1'b0, 1'b0, 1'b0, 12'h000, "blanked cell 10,5");
        send_pt(8'd12, 7'd6, 1'b0, acc);
        chk_acc(acc, "pt 12,6 outside");
        chk_count(16'd2, "pt 12,6");
        read_px(10'd192, 10'd59, 1'b1, 1'b0, 1'b0, 12'h00F, "cell 12,6 blue");
    endtask

    task automatic test_out_of_range();
        logic acc;
        send_pt(8'd205, 7'd3, 1'b1, acc);
        chk_acc(acc, "pt x=205");
        chk_count(16'd2, "pt x=205 dropped");
        read_px(10'd164, 10'd67, 1'b1, 1'b0, 1'b0, 12'h000, "alias of x=205");
        send_pt(8'd40, 7'd2, 1'b1, acc);
        chk_acc(acc, "pt x=FB_W");
        send_pt(8'd7, 7'd12, 1'b1, acc);
        chk_acc(acc, "pt y=FB_H");
        chk_count(16'd2, "edge drops");
        send_pt(8'd39, 7'd11, 1'b1, acc);
        chk_acc(acc, "pt 39,11");
        chk_count(16'd3, "pt 39,11");
        read_px(10'd300, 10'd79, 1'b1, 1'b0, 1'b0, BORDER ? 12'hFFF : 12'hF00, "cell 39,11");
    endtask

    task automatic test_sync_delay();
        read_px(10'd200, 10'd100, 1'b0, 1'b0, 1'b0, 12'h000, "sync prime");
        for (int k = 0; k < 4 && !pix_en; k++) tick();
        hs_in = 1'b1; vs_in = 1'b0; vid_sel = 1'b0;
        tick();
        hs_in = 1'b0; vs_in = 1'b1;
        n_total++;
        if ({vga_hs, vga_vs} !== 2'b00) begin
            n_bad++;
            $display("FAIL sync N+1: got %b%b want 00", vga_hs, vga_vs);
        end
        tick();
        n_total++;
        if ({vga_hs, vga_vs} !== 2'b10) begin
            n_bad++;
            $display("FAIL sync N+2: got %b%b want 10", vga_hs, vga_vs);
        end
        repeat (3) tick();
        n_total++;
        if ({vga_hs, vga_vs} !== 2'b10) begin
            n_bad++;
            $display("FAIL sync hold N+5: got %b%b want 10", vga_hs, vga_vs);
        end
        tick();
        n_total++;
        if ({vga_hs, vga_vs} !== 2'b01) begin
            n_bad++;
            $display("FAIL sync N+6: got %b%b want 01", vga_hs, vga_vs);
        end
    endtask

    task automatic test_border();
        logic acc;
        send_pt(8'd0, 7'd0, 1'b1, acc);
        chk_acc(acc, "pt 0,0");
        chk_count(16'd4, "pt 0,0");
        read_px(10'd144, 10'd35, 1'b1, 1'b0, 1'b0, BORDER ? 12'hFFF : 12'hF00, "cell 0,0 tl");
        read_px(10'd147, 10'd38, 1'b1, 1'b0, 1'b0, BORDER ? 12'hFFF : 12'hF00, "cell 0,0 br");
        read_px(10'd148, 10'd39, 1'b1, 1'b0, 1'b0, 12'h000, "cell 1,1");
    endtask

    task automatic test_clear_collision();
        int n;
        for (int k = 0; k < 4 && pix_en; k++) tick();
        pt_valid = 1'b1; pt_x = 8'd3; pt_y = 7'd3; pt_inside = 1'b1; clear_req = 1'b1;
        #1;
        n_total++;
        if (pt_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL collision ready: got %b want 0", pt_ready);
        end
        tick();
        clear_req = 1'b0; pt_valid = 1'b0;
        n_total++;
        if (clear_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL collision busy: got %b want 1", clear_busy);
        end
        chk_count(16'd0, "collision");
        // A second request mid-wipe must not lengthen it.
        repeat (50) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_clear(n);
        chk_dur(n + 51, "wipe with ignored req");
        read_px(10'd184, 10'd55, 1'b1, 1'b0, 1'b0, 12'h000, "wiped cell 10,5");
        read_px(10'd144, 10'd35, 1'b1, 1'b0, 1'b0, BORDER ? 12'hFFF : 12'h000, "wiped cell 0,0");
        // Reset mid-wipe restarts from address 0.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_clear(n);
        chk_dur(n, "wipe after mid-reset");
        chk_count(16'd0, "after mid-reset");
    endtask

    task automatic test_saturation();
        int   acc = 0;
        int   cycles = 0;
        logic r;
        pt_valid = 1'b1; pt_x = 8'd5; pt_y = 7'd5; pt_inside = 1'b1;
        while (acc < 65537 && cycles < 90000) begin
            #1;
            r = pt_ready;
            n_total++;
            if (r !== ~pix_en) begin
                n_bad++;
                $display("FAIL ready vs pix_en: got %b pix_en=%b", r, pix_en);
            end
            tick();
            cycles++;
            if (r) begin
                acc++;
                if (acc == 65534) chk_count(16'hFFFE, "sat minus one");
            end
        end
        pt_valid = 1'b0;
        n_total++;
        if (acc != 65537) begin
            n_bad++;
            $display("FAIL sat accepts: got %0d want 65537", acc);
        end
        chk_count(16'hFFFF, "saturated");
        read_px(10'd164, 10'd55, 1'b1, 1'b0, 1'b0, 12'hF00, "cell 5,5 after sat");
    endtask

    initial begin
        test_reset();
        test_point_write();
        test_out_of_range();
        test_sync_delay();
        test_border();
        test_clear_collision();
        test_saturation();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
